chunked_subtractor_n: RTL and testbench



---
 rtl/chunked_subtractor_n.sv | 177 +++++++++++++++++
 tb/tb_chunked_subtractor_n.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_subtractor_n.sv
// chunked_subtractor_n
// Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, with borrow-out.
// Each RUN cycle handles CHUNK bits, LSB chunk first. The borrow ripples
// between chunks through a register, so the critical path stays CHUNK bits
// long. A start/done handshake surrounds the operation.
// Optional macro SUB_OVF_EN adds the registered signed-overflow output ovf.
module chunked_subtractor_n #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCH - 1);

    generate
        if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("chunked_subtractor_n: need 1 <= CHUNK <= WIDTH and WIDTH %% CHUNK == 0");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // Operands are shifted right each RUN cycle so the active chunk is
    // always in the low CHUNK bits; no wide index mux is needed.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] work;
    logic             borrow;
    logic [CNT_W-1:0] cnt;

    logic [CHUNK:0]   chunk_res;
    logic [WIDTH-1:0] work_next;
    logic             accept;

`ifdef SUB_OVF_EN
    // Only the sign bits of the captured operands are needed for overflow.
    logic a_msb;
    logic b_msb;
    logic ovf_next;
`endif

    // Ripple of per-bit full subtractors over one chunk.
    // Returns {borrow_out, difference}.
    function automatic logic [CHUNK:0] sub_chunk(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             bi
    );
        logic [CHUNK-1:0] d;
        logic             br;
        br = bi;
        d  = '0;
        for (int i = 0; i < CHUNK; i++) begin
            d[i] = x[i] ^ y[i] ^ br;
            br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
        end
        return {br, d};
    endfunction

    // A new operation can be accepted from IDLE or from the DONE cycle.
    assign accept = start && (state == IDLE || state == DONE);

    // Subtract the current low chunk against the registered borrow.
    always_comb begin
        chunk_res = sub_chunk(a_sh[CHUNK-1:0], b_sh[CHUNK-1:0], borrow);
    end

    // New chunks enter the working result from the top and shift down, so
    // after NCH cycles the first chunk has reached bit 0.
    generate
        if (CHUNK == WIDTH) begin : g_single_chunk
            always_comb begin
                work_next = chunk_res[CHUNK-1:0];
            end
        end else begin : g_multi_chunk
            always_comb begin
                work_next = {chunk_res[CHUNK-1:0], work[WIDTH-1:CHUNK]};
            end
        end
    endgenerate

`ifdef SUB_OVF_EN
    // Two's-complement overflow: operand signs differ and the result sign
    // does not match the minuend.
    always_comb begin
        ovf_next = (a_msb != b_msb) && (work_next[WIDTH-1] != a_msb);
    end
`endif

    // Control FSM, operand capture, chunk iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            work   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
`ifdef SUB_OVF_EN
            ovf    <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sh   <= a;
                b_sh   <= b;
                borrow <= bin;
                work   <= '0;
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= RUN;
`ifdef SUB_OVF_EN
                a_msb  <= a[WIDTH-1];
                b_msb  <= b[WIDTH-1];
`endif
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    RUN: begin
                        a_sh   <= a_sh >> CHUNK;
                        b_sh   <= b_sh >> CHUNK;
                        work   <= work_next;
                        borrow <= chunk_res[CHUNK];
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            diff  <= work_next;
                            bout  <= chunk_res[CHUNK];
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
`ifdef SUB_OVF_EN
                            ovf   <= ovf_next;
`endif
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chunked_subtractor_n.sv
// Testbench for chunked_subtractor_n: scoreboard of expected results fed by
// the stimulus process, popped by a monitor on every done pulse. Two extra
// instances cover CHUNK=WIDTH and CHUNK=1.
module tb_chunked_subtractor_n;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NCH   = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_OVF_EN
    logic             ovf;
`endif

    always #5 clk = ~clk;

    chunked_subtractor_n #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bo;
        logic             ov;
        int               acc;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                   input logic ibin, input int acc);
        exp_t e;
        int ua, ub, bi, r, sa, sb, sr;
        ua = int'(ia);
        ub = int'(ib);
        bi = int'(ibin);
        r  = ua - ub - bi;
        sa = int'($signed(ia));
        sb = int'($signed(ib));
        sr = sa - sb - bi;
        e.d   = r[WIDTH-1:0];
        e.bo  = (r < 0);
        e.ov  = (sr > 32767) || (sr < -32768);
        e.acc = acc;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation.
    exp_t mon_e;
    int   last_done = -1;
    int   prev_done = -1;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            prev_done = last_done;
            last_done = cyc;
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done=1 diff=0x%0h, required no pending operation", diff);
            end else begin
                mon_e = q.pop_front();
                check("diff", 32'(diff), 32'(mon_e.d));
                check("bout", 32'(bout), 32'(mon_e.bo));
                check("latency", 32'(cyc - mon_e.acc), 32'(NCH));
                check("busy_at_done", 32'(busy), 32'd0);
`ifdef SUB_OVF_EN
                check("ovf", 32'(ovf), 32'(mon_e.ov));
`endif
            end
        end
    end

    // Drive one request at a negedge while the DUT is ready; push its
    // expectation once accepted, then scramble the inputs.
    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic ibin);
        exp_t e;
        start = 1'b1;
        a     = ia;
        b     = ib;
        bin   = ibin;
        @(posedge clk);
        #1;
        e = model(ia, ib, ibin, cyc);
        q.push_back(e);
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        bin   = 1'($urandom);
    endtask

    // Corner-parameter instances, each with its own reset and checker loop.
    for (genvar g = 0; g < 2; g++) begin : g_corner
        localparam int CH = (g == 0) ? WIDTH : 1;
        localparam int CN = WIDTH / CH;

        logic             c_rst_n;
        logic             c_start;
        logic [WIDTH-1:0] c_a;
        logic [WIDTH-1:0] c_b;
        logic             c_bin;
        logic             c_busy;
        logic             c_done;
        logic [WIDTH-1:0] c_diff;
        logic             c_bout;
        logic             fin = 1'b0;
`ifdef SUB_OVF_EN
        logic             c_ovf;
`endif

        chunked_subtractor_n #(.WIDTH(WIDTH), .CHUNK(CH)) u_corner (
            .clk   (clk),
            .rst_n (c_rst_n),
            .start (c_start),
            .a     (c_a),
            .b     (c_b),
            .bin   (c_bin),
            .busy  (c_busy),
            .done  (c_done),
            .diff  (c_diff),
            .bout  (c_bout)
`ifdef SUB_OVF_EN
            ,
            .ovf   (c_ovf)
`endif
        );

        initial begin
            exp_t ce;
            int   waited;
            c_rst_n = 1'b0;
            c_start = 1'b0;
            c_a     = '0;
            c_b     = '0;
            c_bin   = 1'b0;
            repeat (3) @(negedge clk);
            c_rst_n = 1'b1;
            @(negedge clk);
            for (int n = 0; n < 200; n++) begin
                case (n)
                    0: begin c_a = 16'h0000; c_b = 16'hFFFF; c_bin = 1'b1; end
                    1: begin c_a = 16'hFFFF; c_b = 16'h0000; c_bin = 1'b0; end
                    2: begin c_a = 16'h0000; c_b = 16'h0000; c_bin = 1'b1; end
                    3: begin c_a = 16'h7FFF; c_b = 16'hFFFF; c_bin = 1'b0; end
                    default: begin
                        c_a   = 16'($urandom);
                        c_b   = 16'($urandom);
                        c_bin = 1'($urandom);
                    end
                endcase
                c_start = 1'b1;
                @(posedge clk);
                #1;
                c_start = 1'b0;
                ce = model(c_a, c_b, c_bin, 0);
                c_a = 16'($urandom);
                c_b = 16'($urandom);
                waited = 0;
                while (c_done !== 1'b1 && waited < CN + 6) begin
                    @(negedge clk);
                    waited++;
                end
                check("corner_done_seen", 32'(c_done), 32'd1);
                check("corner_latency", 32'(waited - 1), 32'(CN));
                check("corner_diff", 32'(c_diff), 32'(ce.d));
                check("corner_bout", 32'(c_bout), 32'(ce.bo));
`ifdef SUB_OVF_EN
                check("corner_ovf", 32'(c_ovf), 32'(ce.ov));
`endif
            end
            fin = 1'b1;
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {28'd0, busy, done, bout, 1'b0}, 32'd0);
        check("reset_diff", 32'(diff), 32'd0);
        rst_n = 1'b1;

        // Idle with start low: nothing moves.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_hold", {13'd0, busy, done, bout, diff}, 32'd0);
        end

        // Basic operation with busy/done timing.
        issue(16'h1234, 16'h0235, 1'b0);
        for (int k = 0; k < NCH; k++) begin
            @(negedge clk);
            check("busy_during_run", {30'd0, busy, done}, 32'b10);
            check("diff_stable_run", 32'(diff), 32'd0);
        end
        @(negedge clk);
        check("done_pulse", {30'd0, busy, done}, 32'b01);
        repeat (3) @(negedge clk);
        check("hold_diff", 32'(diff), 32'h0FFF);
        check("hold_bout", 32'(bout), 32'd0);
        check("done_single_cycle", 32'(done), 32'd0);

        // Borrow wrap, then back-to-back start in the DONE cycle.
        issue(16'h0000, 16'h0001, 1'b0);
        repeat (NCH + 1) @(negedge clk);
        check("done_before_b2b", 32'(done), 32'd1);
        issue(16'h8000, 16'h0000, 1'b1);
        check("b2b_busy", {30'd0, busy, done}, 32'b10);
        check("b2b_prev_diff_held", 32'(diff), 32'hFFFF);
        repeat (NCH + 1) @(negedge clk);
        @(negedge clk);
        check("b2b_done_spacing", 32'(last_done - prev_done), 32'(NCH + 1));
        check("b2b_diff", 32'(diff), 32'h7FFF);

        // Start pulsed during RUN is ignored.
        issue(16'h5555, 16'h1111, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'h0000;
        bin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (NCH + 4) @(negedge clk);
        check("ignored_start_queue", 32'(q.size()), 32'd0);
        check("ignored_start_diff", 32'(diff), 32'h4444);

        // Reset in the middle of RUN aborts with no done.
        issue(16'h4321, 16'h1234, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        #1;
        check("midrun_reset_busy", 32'(busy), 32'd0);
        check("midrun_reset_done", 32'(done), 32'd0);
        check("midrun_reset_diff", 32'(diff), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (NCH + 3) @(negedge clk);
        check("after_abort_diff", 32'(diff), 32'd0);
        issue(16'h0010, 16'h0001, 1'b0);
        repeat (NCH + 2) @(negedge clk);
        check("after_abort_result", 32'(diff), 32'h000F);

        // Random vectors, mixing back-to-back and idle gaps.
        for (int n = 0; n < 1000; n++) begin
            issue(16'($urandom), 16'($urandom), 1'($urandom));
            repeat (NCH + 1 + $urandom_range(0, 2)) @(negedge clk);
        end
        repeat (NCH + 3) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);

        for (int i = 0; i < 20000 && !(g_corner[0].fin && g_corner[1].fin); i++) begin
            @(negedge clk);
        end
        check("corners_finished", {30'd0, g_corner[1].fin, g_corner[0].fin}, 32'b11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
